// File: rtl/spi_txn_decoder.sv
// SPI transaction decoder: turns a chip-selected byte stream into {cmd, addr, len, trunc} records.
// Optional build macro SPI_TXN_READ_FILTER_EN: only read opcodes (0x03, 0x0B) produce records.
module spi_txn_decoder #(
  parameter int LEN_W = 16
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             spi_cs,
  input  logic             rx_strobe,
  input  logic [7:0]       rx_data,
  output logic             txn_valid,
  input  logic             txn_ready,
  output logic [7:0]       txn_cmd,
  output logic [23:0]      txn_addr,
  output logic [LEN_W-1:0] txn_len,
  output logic             txn_trunc,
  output logic [7:0]       drop_count
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_e;

  logic [2:0]       cs_sync_q, sync_vld_q;
  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       acnt_q, acnt_d;

  logic             valid_q, valid_d, trunc_q, trunc_d;
  logic [7:0]       ocmd_q, ocmd_d, drop_q, drop_d;
  logic [23:0]      oaddr_q, oaddr_d;
  logic [LEN_W-1:0] olen_q, olen_d;

  logic cs_fall, cs_rise, rec_fire, rec_trunc, rec_pass;

  // sync_vld_q marks stages that hold a real pin sample rather than the reset value, so a CS
  // already low at reset release is not mistaken for a fresh falling edge.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      cs_sync_q  <= 3'b111;
      sync_vld_q <= 3'b000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      cs_sync_q  <= {cs_sync_q[1:0], spi_cs};
      sync_vld_q <= {sync_vld_q[1:0], 1'b1};
    end
  end

  assign cs_fall = sync_vld_q[2] &  cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise = sync_vld_q[2] & ~cs_sync_q[2] &  cs_sync_q[1];

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      acnt_q  <= acnt_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    len_d   = len_q;
    acnt_d  = acnt_q;
    if (rx_strobe) begin
      unique case (state_q)
        IDLE: ;
        CMD: begin
          cmd_d   = rx_data;
          state_d = (rx_data inside {8'h03, 8'h0B, 8'h02, 8'h20, 8'hD8}) ? ADDR : DATA;
        end
        ADDR: begin
          addr_d = {addr_q[15:0], rx_data};
          acnt_d = acnt_q + 2'd1;
          if (acnt_q == 2'd2) state_d = (cmd_q == 8'h0B) ? DUMMY : DATA;
        end
        DUMMY: state_d = DATA;
        DATA:  if (len_q != '1) len_d = len_q + LEN_W'(1);
      endcase
    end
    // The record is formed from the post-strobe view so a coincident final byte is included.
    rec_fire  = cs_rise && (state_d inside {ADDR, DUMMY, DATA});
    rec_trunc = (state_d == ADDR) || (state_d == DUMMY);
    if (cs_rise) state_d = IDLE;
    if (cs_fall) begin
      state_d = CMD;
      cmd_d   = '0;
      addr_d  = '0;
      len_d   = '0;
      acnt_d  = '0;
    end
  end

`ifdef SPI_TXN_READ_FILTER_EN
  assign rec_pass = (cmd_d == 8'h03) || (cmd_d == 8'h0B);
`else
  assign rec_pass = 1'b1;
`endif

  always_comb begin
    valid_d = valid_q;
    ocmd_d  = ocmd_q;
    oaddr_d = oaddr_q;
    olen_d  = olen_q;
    trunc_d = trunc_q;
    drop_d  = drop_q;
    if (valid_q && txn_ready) valid_d = 1'b0;
    if (rec_fire && rec_pass) begin
      if (!valid_q || txn_ready) begin
        valid_d = 1'b1;
        ocmd_d  = cmd_d;
        oaddr_d = addr_d;
        olen_d  = len_d;
        trunc_d = rec_trunc;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ocmd_q  <= '0;
      oaddr_q <= '0;
      olen_q  <= '0;
      trunc_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ocmd_q  <= ocmd_d;
      oaddr_q <= oaddr_d;
      olen_q  <= olen_d;
      trunc_q <= trunc_d;
      drop_q  <= drop_d;
    end
  end

  assign txn_valid  = valid_q;
  assign txn_cmd    = ocmd_q;
  assign txn_addr   = oaddr_q;
  assign txn_len    = olen_q;
  assign txn_trunc  = trunc_q;
  assign drop_count = drop_q;

endmodule
